// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, the bubble
// instruction word, FSM state encoding, instruction field positions and the
// mask-scan helper functions used by the LM/SM sequencer.
package pipe_ctrl_pkg;

  localparam logic [3:0]  OP_LW  = 4'b0100;
  localparam logic [3:0]  OP_LM  = 4'b0110;
  localparam logic [3:0]  OP_SM  = 4'b0111;
  localparam logic [15:0] NOP_IR = 16'hF000;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int RB_MSB   = 8;
  localparam int RB_LSB   = 6;
  localparam int MASK_MSB = 7;
  localparam int MASK_LSB = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  // Mask bit i names register 7-i, and the highest set bit is served first,
  // so the register returned is the lowest-numbered one still pending.
  function automatic logic [2:0] leadReg(input logic [7:0] mask);
    logic [2:0] result;
    result = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        result = 3'(7 - i);
      end
    end
    return result;
  endfunction

  // Removes the bit that leadReg picked, leaving the beats still to issue.
  function automatic logic [7:0] clearLead(input logic [7:0] mask);
    logic [7:0] result;
    logic       done;
    result = mask;
    done   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && !done) begin
        result[i] = 1'b0;
        done      = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/multi_reg_scan.sv
// LM/SM register scanner: holds the remaining-beat mask, encodes the register
// for the current beat and flags the final beat. While the owner is not yet
// sequencing, the mask straight from the instruction is examined so the first
// beat can issue in the entry cycle.
module multi_reg_scan
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       useMask_i,
  input  logic [7:0] idMask_i,
  input  logic       step_i,
  input  logic       abort_i,
  output logic [2:0] regSel_o,
  output logic       lastBeat_o,
  output logic       multiBeat_o
);

  logic [7:0] maskQ;
  logic [7:0] maskD;
  logic [7:0] curMask;
  logic [7:0] remMask;

  // Pick the mask for this beat, derive its register and what remains after it.
  always_comb begin
    curMask     = useMask_i ? maskQ : idMask_i;
    remMask     = clearLead(curMask);
    regSel_o    = leadReg(curMask);
    lastBeat_o  = (remMask == 8'd0);
    multiBeat_o = (curMask != 8'd0) && (remMask != 8'd0);
  end

  // A flush discards pending beats; an issued beat retires its register.
  always_comb begin
    maskD = maskQ;
    if (abort_i) begin
      maskD = 8'd0;
    end else if (step_i) begin
      maskD = remMask;
    end
  end

  // Remaining-beat mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maskQ <= 8'd0;
    end else begin
      maskQ <= maskD;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives every enable and clear of the IF_ID,
// ID_RR, RR_EX and EX_MEM registers. Handles EX redirect flushes, memory-busy
// freezes, load-use bubbles and one-register-per-cycle LM/SM sequencing.
// Clears are registered so the asynchronous CLR pins never see a glitch.
// Build option HAZ_PERF_CNT_EN adds saturating STALL_CNT / FLUSH_CNT outputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ID_RR_IR,
  input  logic [15:0] RR_EX_IR,
  input  logic [2:0]  RR_EX_DEST,
  input  logic        EX_BR_TAKEN,
  input  logic        MEM_BUSY,
  output logic        PC_EN,
  output logic        IF_ID_EN,
  output logic        ID_RR_EN,
  output logic        RR_EX_EN,
  output logic        EX_MEM_EN,
  output logic        IF_ID_CLR,
  output logic        ID_RR_CLR,
  output logic        RR_EX_CLR,
  output logic        RR_EX_BUBBLE,
  output logic [2:0]  MULTI_REG_SEL,
  output logic        MULTI_ACTIVE,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT,
`endif
  output logic [1:0]  STATE
);

  ctrl_state_e stateQ;
  ctrl_state_e stateD;
  logic        clrQ;
  logic        isMultiOp;
  logic        loadUse;
  logic        startMulti;
  logic        inMulti;
  logic        scanStep;
  logic [2:0]  scanSel;
  logic        scanLast;
  logic        scanMulti;
  logic        unusedRrExBits;

  assign unusedRrExBits = ^RR_EX_IR[RA_MSB:0];

  // Decode the RR-stage instruction and the EX-stage load against it.
  always_comb begin
    isMultiOp  = (ID_RR_IR[OPC_MSB:OPC_LSB] == OP_LM) ||
                 (ID_RR_IR[OPC_MSB:OPC_LSB] == OP_SM);
    loadUse    = (RR_EX_IR[OPC_MSB:OPC_LSB] == OP_LW) &&
                 ((RR_EX_DEST == ID_RR_IR[RA_MSB:RA_LSB]) ||
                  (RR_EX_DEST == ID_RR_IR[RB_MSB:RB_LSB]));
    inMulti    = (stateQ == MULTI);
    startMulti = (stateQ == RUN) && isMultiOp && !loadUse && scanMulti;
    scanStep   = !MEM_BUSY && (startMulti || inMulti);
  end

  multi_reg_scan u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .useMask_i   (inMulti),
    .idMask_i    (ID_RR_IR[MASK_MSB:MASK_LSB]),
    .step_i      (scanStep),
    .abort_i     (EX_BR_TAKEN),
    .regSel_o    (scanSel),
    .lastBeat_o  (scanLast),
    .multiBeat_o (scanMulti)
  );

  // State register plus the registered clear that mirrors the FLUSH state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= RUN;
      clrQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      clrQ   <= (stateD == FLUSH);
    end
  end

  // Next state: redirect beats everything, a busy memory holds the state.
  always_comb begin
    stateD = stateQ;
    if (EX_BR_TAKEN) begin
      stateD = FLUSH;
    end else if (!MEM_BUSY) begin
      case (stateQ)
        RUN:     if (startMulti) stateD = MULTI;
        MULTI:   if (scanLast) stateD = RUN;
        FLUSH:   stateD = RUN;
        default: stateD = RUN;
      endcase
    end
  end

  // Enables, bubble and LM/SM status; held at reset values while in reset.
  always_comb begin
    PC_EN         = 1'b1;
    IF_ID_EN      = 1'b1;
    ID_RR_EN      = 1'b1;
    RR_EX_EN      = 1'b1;
    EX_MEM_EN     = 1'b1;
    RR_EX_BUBBLE  = 1'b0;
    MULTI_ACTIVE  = 1'b0;
    MULTI_REG_SEL = 3'd0;
    if (rst_n) begin
      if (inMulti || ((stateQ == RUN) && isMultiOp && !loadUse)) begin
        MULTI_REG_SEL = scanSel;
      end
      MULTI_ACTIVE = inMulti || startMulti;
      if (MEM_BUSY) begin
        PC_EN     = 1'b0;
        IF_ID_EN  = 1'b0;
        ID_RR_EN  = 1'b0;
        RR_EX_EN  = 1'b0;
        EX_MEM_EN = 1'b0;
      end else begin
        case (stateQ)
          MULTI: begin
            if (!scanLast) begin
              PC_EN    = 1'b0;
              IF_ID_EN = 1'b0;
              ID_RR_EN = 1'b0;
            end
          end
          RUN: begin
            if (loadUse) begin
              PC_EN        = 1'b0;
              IF_ID_EN     = 1'b0;
              ID_RR_EN     = 1'b0;
              RR_EX_BUBBLE = 1'b1;
            end else if (startMulti) begin
              PC_EN    = 1'b0;
              IF_ID_EN = 1'b0;
              ID_RR_EN = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign IF_ID_CLR = clrQ;
  assign ID_RR_CLR = clrQ;
  assign RR_EX_CLR = clrQ;
  assign STATE     = stateQ;

`ifdef HAZ_PERF_CNT_EN
  logic        stallEvent;
  logic [15:0] stallCntQ;
  logic [15:0] flushCntQ;

  assign stallEvent = RR_EX_BUBBLE || (MULTI_ACTIVE && !PC_EN && !MEM_BUSY);

  // Saturating counts of issued stall cycles and of flush entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntQ <= 16'd0;
      flushCntQ <= 16'd0;
    end else begin
      if (stallEvent && (stallCntQ != 16'hFFFF)) begin
        stallCntQ <= stallCntQ + 16'd1;
      end
      if (EX_BR_TAKEN && (flushCntQ != 16'hFFFF)) begin
        flushCntQ <= flushCntQ + 16'd1;
      end
    end
  end

  assign STALL_CNT = stallCntQ;
  assign FLUSH_CNT = flushCntQ;
`endif

endmodule
